// File: rtl/anf_fl_tex_pkg.sv
// Shared texture-path definitions: format/class codes and the bytes-per-texel lookup.
package anf_fl_tex_pkg;

    localparam int unsigned FMT_W = 5;

    typedef enum logic [1:0] {
        CLS_8BPC       = 2'b00,
        CLS_16BIT      = 2'b01,
        CLS_COMPRESSED = 2'b10,
        CLS_TILED      = 2'b11
    } fmt_class_e;

    localparam logic [FMT_W-1:0] FMT_RGB_ETC2      = 5'b00010;
    localparam logic [FMT_W-1:0] FMT_RGBA_32       = 5'b00100;
    localparam logic [FMT_W-1:0] FMT_RGBA_16_TILED = 5'b01111;

    // log2 of bytes per texel; compressed blocks are addressed whole, so 0 there
    function automatic logic [1:0] bpt_log2(input logic [FMT_W-1:0] fmt);
        logic [1:0] r;
        r = 2'd2;
        case (fmt[1:0])
            CLS_8BPC:       r = 2'd2;
            CLS_16BIT:      r = 2'd1;
            CLS_COMPRESSED: r = 2'd0;
            default: begin
                case (fmt[4:2])
                    3'b000, 3'b001:         r = 2'd2;
                    3'b010, 3'b011, 3'b101: r = 2'd1;
                    3'b100:                 r = 2'd0;
                    default:                r = 2'd2;
                endcase
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/anf_fl_tex_addr_gen.sv
// Coordinate wrap and byte-address generation for linear, tiled and block-compressed layouts.
module anf_fl_tex_addr_gen
    import anf_fl_tex_pkg::*;
#(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [ADDR_W-1:0]  base,
    input  logic [3:0]         wlog2,
    input  logic [3:0]         hlog2,
    input  logic [FMT_W-1:0]   format,
    output logic [ADDR_W-5:0]  line,
    output logic [3:0]         offset,
    output logic [1:0]         texel_x,
    output logic [1:0]         texel_y
);

    fmt_class_e         cls;
    logic [3:0]         wl;
    logic [1:0]         bl;
    logic [COORD_W-1:0] xw;
    logic [COORD_W-1:0] yw;
    logic [ADDR_W-1:0]  xa;
    logic [ADDR_W-1:0]  ya;
    logic [ADDR_W-1:0]  lin;
    logic [ADDR_W-1:0]  blk;
    logic [ADDR_W-1:0]  intra;
    logic [ADDR_W-1:0]  rel;
    logic [ADDR_W-1:0]  addr;

    always_comb begin
        cls = fmt_class_e'(format[1:0]);
        // 4x4 block layouts need at least one full block per row
        wl  = ((cls == CLS_COMPRESSED || cls == CLS_TILED) && wlog2 < 4'd2) ? 4'd2 : wlog2;
        bl  = bpt_log2(format);
        xw  = x & ((COORD_W'(1) << wl) - COORD_W'(1));
        yw  = y & ((COORD_W'(1) << hlog2) - COORD_W'(1));
        xa  = ADDR_W'(xw);
        ya  = ADDR_W'(yw);
        lin   = ((ya << wl) + xa) << bl;
        blk   = ((ya >> 2) << (wl - 4'd2)) + (xa >> 2);
        intra = ADDR_W'({yw[1:0], xw[1:0]}) << bl;
        case (cls)
            CLS_COMPRESSED: rel = blk << 4;
            CLS_TILED:      rel = (blk << (3'd4 + 3'(bl))) + intra;
            default:        rel = lin;
        endcase
        addr    = (base & ~ADDR_W'(15)) + rel;
        line    = addr[ADDR_W-1:4];
        offset  = (cls == CLS_COMPRESSED) ? 4'd0 : addr[3:0];
        texel_x = xw[1:0];
        texel_y = yw[1:0];
    end

endmodule

// File: rtl/anf_fl_tex_texel_fetch.sv
// Texel fetch: request capture, one-entry line buffer, memory line read and right-aligning shifter.
module anf_fl_tex_texel_fetch
    import anf_fl_tex_pkg::*;
#(
    parameter int unsigned COORD_W = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [ADDR_W-1:0]  in_base,
    input  logic [3:0]         in_wlog2,
    input  logic [3:0]         in_hlog2,
    input  logic [FMT_W-1:0]   in_format,
    input  logic               inv,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-5:0]  mem_req_addr,
    input  logic               mem_rvalid,
    input  logic [LINE_W-1:0]  mem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LINE_W-1:0]  out_data,
    output logic [FMT_W-1:0]   out_format,
    output logic [1:0]         out_texelX,
    output logic [1:0]         out_texelY
);

    localparam int unsigned LADDR_W = ADDR_W - 4;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_REQ, S_WAIT, S_OUT} state_e;

    state_e             state;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic [ADDR_W-1:0]  req_base;
    logic [3:0]         req_wlog2;
    logic [3:0]         req_hlog2;
    logic [FMT_W-1:0]   req_format;
    logic               lb_valid;
    logic [LADDR_W-1:0] lb_tag;
    logic [LINE_W-1:0]  lb_data;
    logic               inv_seen;

    logic [LADDR_W-1:0] line;
    logic [3:0]         offset;
    logic [1:0]         tx;
    logic [1:0]         ty;
    logic               hit_c;

    anf_fl_tex_addr_gen #(.COORD_W(COORD_W), .ADDR_W(ADDR_W)) u_addr_gen (
        .x       (req_x),
        .y       (req_y),
        .base    (req_base),
        .wlog2   (req_wlog2),
        .hlog2   (req_hlog2),
        .format  (req_format),
        .line    (line),
        .offset  (offset),
        .texel_x (tx),
        .texel_y (ty)
    );

    assign hit_c = lb_valid && !inv && (lb_tag == line);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_format    <= '0;
            out_texelX    <= '0;
            out_texelY    <= '0;
            req_x         <= '0;
            req_y         <= '0;
            req_base      <= '0;
            req_wlog2     <= '0;
            req_hlog2     <= '0;
            req_format    <= '0;
            lb_valid      <= 1'b0;
            lb_tag        <= '0;
            lb_data       <= '0;
            inv_seen      <= 1'b0;
        end else begin
            if (inv) lb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        req_x      <= in_x;
                        req_y      <= in_y;
                        req_base   <= in_base;
                        req_wlog2  <= in_wlog2;
                        req_hlog2  <= in_hlog2;
                        req_format <= in_format;
                        inv_seen   <= 1'b0;
                        in_ready   <= 1'b0;
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (hit_c) begin
                        out_data   <= LINE_W'(lb_data >> {offset, 3'b000});
                        out_format <= req_format;
                        out_texelX <= tx;
                        out_texelY <= ty;
                        out_valid  <= 1'b1;
                        state      <= S_OUT;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= line;
                        state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (inv) inv_seen <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inv) inv_seen <= 1'b1;
                    if (mem_rvalid) begin
                        // a line that raced an invalidate is delivered but never cached
                        lb_tag     <= line;
                        lb_data    <= mem_rdata;
                        lb_valid   <= !inv && !inv_seen;
                        out_data   <= LINE_W'(mem_rdata >> {offset, 3'b000});
                        out_format <= req_format;
                        out_texelX <= tx;
                        out_texelY <= ty;
                        out_valid  <= 1'b1;
                        state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_anf_fl_tex_texel_fetch.sv
// Directed bench for the texel fetch stage: misses, hits, layouts, backpressure, invalidate, reset.
module tb_anf_fl_tex_texel_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_x;
    logic [15:0]  in_y;
    logic [31:0]  in_base;
    logic [3:0]   in_wlog2;
    logic [3:0]   in_hlog2;
    logic [4:0]   in_format;
    logic         inv;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_format;
    logic [1:0]   out_texelX;
    logic [1:0]   out_texelY;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    anf_fl_tex_texel_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_base       (in_base),
        .in_wlog2      (in_wlog2),
        .in_hlog2      (in_hlog2),
        .in_format     (in_format),
        .inv           (inv),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_format    (out_format),
        .out_texelX    (out_texelX),
        .out_texelY    (out_texelY)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request; returns at the falling edge of the CALC cycle.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [31:0] base,
                        input logic [3:0] wl, input logic [3:0] hl, input logic [4:0] fmt);
        @(negedge clk);
        check("in_ready_before_send", 128'(in_ready), 128'd1);
        in_x = x; in_y = y; in_base = base; in_wlog2 = wl; in_hlog2 = hl; in_format = fmt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("calc_no_out", 128'(out_valid), 128'd0);
    endtask

    // Miss path from CALC: check the request, grant it, return a line.
    task automatic miss(input string tag, input logic [27:0] line, input logic [127:0] data);
        @(negedge clk);
        check({tag, "_req_valid"}, 128'(mem_req_valid), 128'd1);
        check({tag, "_req_addr"}, 128'(mem_req_addr), 128'(line));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check({tag, "_req_dropped"}, 128'(mem_req_valid), 128'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [127:0] data, input logic [4:0] fmt,
                              input logic [1:0] tx, input logic [1:0] ty);
        check({tag, "_valid"}, 128'(out_valid), 128'd1);
        check({tag, "_data"}, out_data, data);
        check({tag, "_fmt"}, 128'(out_format), 128'(fmt));
        check({tag, "_tx"}, 128'(out_texelX), 128'(tx));
        check({tag, "_ty"}, 128'(out_texelY), 128'(ty));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", 128'(out_valid), 128'd0);
        check("drain_in_ready", 128'(in_ready), 128'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_base = '0; in_wlog2 = '0;
        in_hlog2 = '0; in_format = '0; inv = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_req_valid", 128'(mem_req_valid), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // RGBA_32 miss, addr 0x1094
        send(16'd5, 16'd2, 32'h1000, 4'd4, 4'd4, 5'b00100);
        @(negedge clk);
        check("t1_req_early", 128'(mem_req_valid), 128'd1);
        mem_req_ready = 1'b0;
        miss("t1", 28'h109, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        expect_out("t1", 128'h00000000_00112233_44556677_8899AABB, 5'b00100, 2'd1, 2'd2);
        drain();

        // neighbouring texel hits the buffered line
        send(16'd6, 16'd2, 32'h1000, 4'd4, 4'd4, 5'b00100);
        @(negedge clk);
        check("t2_no_req", 128'(mem_req_valid), 128'd0);
        expect_out("t2", 128'h00000000_00000000_00112233_44556677, 5'b00100, 2'd2, 2'd2);
        drain();

        // ETC2 block, whole block delivered
        send(16'd9, 16'd6, 32'h2000, 4'd5, 4'd4, 5'b00010);
        miss("t3", 28'h20A, 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F);
        expect_out("t3", 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, 5'b00010, 2'd1, 2'd2);
        drain();

        // 16-bit tiled, addr 0x6C
        send(16'd6, 16'd5, 32'h0, 4'd3, 4'd3, 5'b01111);
        miss("t4", 28'h6, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        expect_out("t4", 128'h00000000_00000000_00000000_DEADBEEF, 5'b01111, 2'd2, 2'd1);
        drain();

        // wrap 17,33 -> 1,1 -> addr 0x44; output held under backpressure
        send(16'd17, 16'd33, 32'h0, 4'd4, 4'd4, 5'b00100);
        miss("t5", 28'h4, 128'h11111111_22222222_33333333_44444444);
        for (int i = 0; i < 3; i++) begin
            expect_out("t5_hold", 128'h00000000_11111111_22222222_33333333, 5'b00100, 2'd1, 2'd1);
            check("t5_in_ready", 128'(in_ready), 128'd0);
            @(negedge clk);
        end
        drain();

        // invalidate while waiting: line delivered but not cached
        send(16'd0, 16'd0, 32'h3000, 4'd4, 4'd4, 5'b00100);
        @(negedge clk);
        check("t6_req_valid", 128'(mem_req_valid), 128'd1);
        check("t6_req_addr", 128'(mem_req_addr), 128'h300);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 128'hCAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        expect_out("t6", 128'hCAFE, 5'b00100, 2'd0, 2'd0);
        drain();
        send(16'd0, 16'd0, 32'h3000, 4'd4, 4'd4, 5'b00100);
        @(negedge clk);
        check("t6_rerequest", 128'(mem_req_valid), 128'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 128'(out_valid), 128'd0);
        check("t6_rst_req_valid", 128'(mem_req_valid), 128'd0);
        check("t6_rst_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_after_rst", 128'(in_ready), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
